// File: rtl/cam_gray_pingpong_writer.sv
// -----------------------------------------------------------------------------
// cam_gray_pingpong_writer
//
// Camera front end for the SAD disparity path. The camera stream (frame valid,
// line valid, pixel clock, packed RGB) is sampled in the clk domain. Each pixel
// is reduced to one gray channel and written through a small FIFO to a frame
// buffer. Frames alternate between two banks so the SAD engine reads one bank
// while the other fills.
//
// Ports
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   cam_frame_valid   camera frame valid, asynchronous to clk
//   cam_line_valid    camera line valid, asynchronous to clk
//   cam_pixel_clk     camera pixel clock, sampled as data
//   cam_pixel_rgb     {R,G,B}, CH_WIDTH bits each, R in the MSBs
//   mode              gray mode: 00 mean, 01 luma, 10 max, 11 green
//   pixel_mean        gray write data (FIFO head)
//   buf_waddr         write address (FIFO head)
//   buf_wvalid        write request, high while the FIFO is not empty
//   buf_wready        buffer accepts the write
//   sad_done          pulse: SAD released the oldest full bank
//   frame_done        pulse: a frame has been completely written
//   done_bank         bank of the most recent frame_done
//   frame_drop        pulse: a frame was skipped because both banks are full
//   overflow          sticky per frame: a pixel was lost to a full FIFO
//   frame_err         sticky per frame: pixel count differed from H*V
// -----------------------------------------------------------------------------
module cam_gray_pingpong_writer #(
   parameter int unsigned CAMERA_HSIZE   = 32'd100,
   parameter int unsigned CAMERA_VSIZE   = 32'd100,
   parameter int unsigned CH_WIDTH       = 32'd4,
   parameter int unsigned BUF_ADDR_WIDTH = 32'd32,
   parameter int unsigned BANK_A_BASE    = 32'd0,
   parameter int unsigned BANK_B_BASE    = 32'd10000,
   parameter int unsigned FIFO_DEPTH     = 32'd4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cam_frame_valid,
   input  logic                      cam_line_valid,
   input  logic                      cam_pixel_clk,
   input  logic [3*CH_WIDTH-1:0]     cam_pixel_rgb,
   input  logic [1:0]                mode,
   output logic [CH_WIDTH-1:0]       pixel_mean,
   output logic [BUF_ADDR_WIDTH-1:0] buf_waddr,
   output logic                      buf_wvalid,
   input  logic                      buf_wready,
   input  logic                      sad_done,
   output logic                      frame_done,
   output logic                      done_bank,
   output logic                      frame_drop,
   output logic                      overflow,
   output logic                      frame_err
);

   localparam int unsigned PIX_W     = 3 * CH_WIDTH;
   localparam int unsigned FRAME_PIX = CAMERA_HSIZE * CAMERA_VSIZE;
   localparam int unsigned IDX_W     = $clog2(FRAME_PIX + 1);
   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned ENT_W     = CH_WIDTH + BUF_ADDR_WIDTH;

   localparam logic [IDX_W-1:0]          FRAME_PIX_C = IDX_W'(FRAME_PIX);
   localparam logic [IDX_W-1:0]          IDX_ZERO    = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]          IDX_ONE     = IDX_W'(1);
   localparam logic [PTR_W-1:0]          PTR_ZERO    = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]          PTR_ONE     = PTR_W'(1);
   localparam logic [CNT_W-1:0]          CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]          CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]          DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [BUF_ADDR_WIDTH-1:0] BANK_A_C    = BUF_ADDR_WIDTH'(BANK_A_BASE);
   localparam logic [BUF_ADDR_WIDTH-1:0] BANK_B_C    = BUF_ADDR_WIDTH'(BANK_B_BASE);

   localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
   localparam logic [1:0] ST_ACTIVE     = 2'd1;
   localparam logic [1:0] ST_DRAIN      = 2'd2;
   localparam logic [1:0] ST_HOLD       = 2'd3;

   // Reduce one {R,G,B} pixel to a single gray channel.
   function automatic logic [CH_WIDTH-1:0] gray_of(input logic [PIX_W-1:0] rgb,
                                                   input logic [1:0]       m);
      logic [CH_WIDTH-1:0] r, g, b, mx;
      logic [CH_WIDTH+1:0] sum3, quo;
      logic [CH_WIDTH+3:0] re, ge, be, lsum;
      logic [CH_WIDTH-1:0] res;
      r    = rgb[PIX_W-1 -: CH_WIDTH];
      g    = rgb[2*CH_WIDTH-1 -: CH_WIDTH];
      b    = rgb[CH_WIDTH-1:0];
      sum3 = {2'b00, r} + {2'b00, g} + {2'b00, b};
      quo  = sum3 / {{CH_WIDTH{1'b0}}, 2'b11};
      re   = {4'b0000, r};
      ge   = {4'b0000, g};
      be   = {4'b0000, b};
      // 5R + 9G + 2B built from shifts; the sum fits CH_WIDTH+4 bits.
      lsum = (re << 2) + re + (ge << 3) + ge + (be << 1);
      if (r >= g && r >= b) begin
         mx = r;
      end else if (g >= b) begin
         mx = g;
      end else begin
         mx = b;
      end
      case (m)
         2'b00:   res = quo[CH_WIDTH-1:0];
         2'b01:   res = lsum[CH_WIDTH+3:4];
         2'b10:   res = mx;
         2'b11:   res = g;
         default: res = g;
      endcase
      return res;
   endfunction

   logic                      fv_meta_r, fv_s, fv_d_r;
   logic                      lv_meta_r, lv_s;
   logic                      pc_meta_r, pc_s, pc_d_r;
   logic                      strobe_s, fv_rise_s, fv_fall_s;

   logic [1:0]                state_r;
   logic [1:0]                mode_r;
   logic [IDX_W-1:0]          idx_r;
   logic                      wbank_r;
   logic [1:0]                full_r;
   logic                      push_pend_r;
   logic [CH_WIDTH-1:0]       push_gray_r;
   logic [BUF_ADDR_WIDTH-1:0] push_addr_r;
   logic                      frame_done_r, done_bank_r, frame_drop_r;
   logic                      overflow_r, frame_err_r;

   logic [ENT_W-1:0]          mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r, rd_next_s;
   logic [CNT_W-1:0]          count_r, cnt_after_pop_s, count_next_s;
   logic [ENT_W-1:0]          head_r, head_next_s, push_entry_s;
   logic                      wvalid_r;
   logic                      pop_s, push_s, drop_s, full_s;

   logic [BUF_ADDR_WIDTH-1:0] bank_base_s;
   logic [1:0]                full_rel_s, full_mark_s;
   logic                      drain_done_s;

   // Two-flop synchronizers plus edge history. The frame-valid chain resets
   // high so a frame already in progress at reset release is not taken as a
   // rising edge; only a genuine low-to-high transition starts a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fv_meta_r <= 1'b1;
         fv_s      <= 1'b1;
         fv_d_r    <= 1'b1;
         lv_meta_r <= 1'b0;
         lv_s      <= 1'b0;
         pc_meta_r <= 1'b0;
         pc_s      <= 1'b0;
         pc_d_r    <= 1'b0;
      end else begin
         fv_meta_r <= cam_frame_valid;
         fv_s      <= fv_meta_r;
         fv_d_r    <= fv_s;
         lv_meta_r <= cam_line_valid;
         lv_s      <= lv_meta_r;
         pc_meta_r <= cam_pixel_clk;
         pc_s      <= pc_meta_r;
         pc_d_r    <= pc_s;
      end
   end

   assign strobe_s    = pc_s && !pc_d_r && fv_s && lv_s;
   assign fv_rise_s   = fv_s && !fv_d_r;
   assign fv_fall_s   = !fv_s && fv_d_r;
   assign bank_base_s = wbank_r ? BANK_B_C : BANK_A_C;

   // FIFO handshake decode and next head entry for the registered outputs.
   always_comb begin
      pop_s        = wvalid_r && buf_wready;
      full_s       = (count_r == DEPTH_C);
      push_s       = push_pend_r && (!full_s || pop_s);
      drop_s       = push_pend_r && full_s && !pop_s;
      push_entry_s = {push_gray_r, push_addr_r};
      rd_next_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      cnt_after_pop_s = pop_s ? (count_r - CNT_ONE) : count_r;
      count_next_s    = push_s ? (cnt_after_pop_s + CNT_ONE) : cnt_after_pop_s;
      // If nothing older remains after the pop, the incoming entry becomes
      // the head; otherwise the head is the next stored entry.
      if (cnt_after_pop_s == CNT_ZERO) begin
         head_next_s = push_entry_s;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Bank flags: a release frees the oldest full bank before the finishing
   // frame marks its own bank. With both banks full, the oldest is the one the
   // writer points at, since the write bank toggles after every frame.
   always_comb begin
      drain_done_s = (state_r == ST_DRAIN) && (count_r == CNT_ZERO) && !push_pend_r;
      full_rel_s   = full_r;
      if (sad_done && (full_r != 2'b00)) begin
         if (full_r == 2'b11) begin
            full_rel_s[wbank_r] = 1'b0;
         end else begin
            full_rel_s = 2'b00;
         end
      end else begin
         full_rel_s = full_r;
      end
      full_mark_s = full_rel_s;
      if (drain_done_s) begin
         full_mark_s[wbank_r] = 1'b1;
      end else begin
         full_mark_s = full_rel_s;
      end
   end

   // Frame control: state, pixel index, gray stage, bank bookkeeping, flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_WAIT_FRAME;
         mode_r       <= 2'b00;
         idx_r        <= IDX_ZERO;
         wbank_r      <= 1'b0;
         full_r       <= 2'b00;
         push_pend_r  <= 1'b0;
         push_gray_r  <= {CH_WIDTH{1'b0}};
         push_addr_r  <= {BUF_ADDR_WIDTH{1'b0}};
         frame_done_r <= 1'b0;
         done_bank_r  <= 1'b0;
         frame_drop_r <= 1'b0;
         overflow_r   <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         frame_done_r <= 1'b0;
         frame_drop_r <= 1'b0;
         push_pend_r  <= 1'b0;
         full_r       <= full_mark_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         case (state_r)
            ST_WAIT_FRAME: begin
               if (fv_rise_s) begin
                  state_r     <= ST_ACTIVE;
                  idx_r       <= IDX_ZERO;
                  overflow_r  <= 1'b0;
                  frame_err_r <= 1'b0;
                  mode_r      <= mode;
               end
            end
            ST_ACTIVE: begin
               if (fv_fall_s) begin
                  state_r <= ST_DRAIN;
                  if (idx_r != FRAME_PIX_C) begin
                     frame_err_r <= 1'b1;
                  end
               end else if (strobe_s) begin
                  // idx advances even if the FIFO later drops the pixel,
                  // leaving an address gap rather than shifting the image.
                  if (idx_r < FRAME_PIX_C) begin
                     push_pend_r <= 1'b1;
                     push_gray_r <= gray_of(cam_pixel_rgb, mode_r);
                     push_addr_r <= bank_base_s
                                    + {{(BUF_ADDR_WIDTH-IDX_W){1'b0}}, idx_r};
                     idx_r       <= idx_r + IDX_ONE;
                  end else begin
                     frame_err_r <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  frame_done_r <= 1'b1;
                  done_bank_r  <= wbank_r;
                  wbank_r      <= !wbank_r;
                  state_r      <= full_mark_s[!wbank_r] ? ST_HOLD : ST_WAIT_FRAME;
               end
            end
            ST_HOLD: begin
               if (fv_rise_s) begin
                  frame_drop_r <= 1'b1;
               end
               if (!full_rel_s[wbank_r]) begin
                  state_r <= ST_WAIT_FRAME;
               end
            end
            default: begin
               state_r <= ST_WAIT_FRAME;
            end
         endcase
      end
   end

   // FIFO pointers, occupancy and the registered head presented to the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         wvalid_r <= 1'b0;
         head_r   <= {ENT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_next_s;
         wvalid_r <= (count_next_s != CNT_ZERO);
         if (count_next_s != CNT_ZERO) begin
            head_r <= head_next_s;
         end
      end
   end

   // FIFO payload storage; validity is tracked by count_r, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_entry_s;
      end
   end

   assign pixel_mean = head_r[ENT_W-1 -: CH_WIDTH];
   assign buf_waddr  = head_r[BUF_ADDR_WIDTH-1:0];
   assign buf_wvalid = wvalid_r;
   assign frame_done = frame_done_r;
   assign done_bank  = done_bank_r;
   assign frame_drop = frame_drop_r;
   assign overflow   = overflow_r;
   assign frame_err  = frame_err_r;

endmodule
